// File: rtl/mo_response_capture_if.sv
// rtl/mo_response_capture_if.sv - stimulus/response bundle between the capture stage and its driver.
interface mo_response_capture_if #(
   parameter int CNT_W = 5
);
   logic             start;
   logic             abort;
   logic             Falpha;
   logic             Fbeta;
   logic             Fgamma;
   logic [3:0]       vec_out;
   logic             busy;
   logic             done;
   logic             result_valid;
   logic [15:0]      signature;
   logic [CNT_W-1:0] cnt_alpha;
   logic [CNT_W-1:0] cnt_beta;
   logic [CNT_W-1:0] cnt_gamma;

   modport master (
      output start, abort, Falpha, Fbeta, Fgamma,
      input  vec_out, busy, done, result_valid, signature,
             cnt_alpha, cnt_beta, cnt_gamma
   );

   modport slave (
      input  start, abort, Falpha, Fbeta, Fgamma,
      output vec_out, busy, done, result_valid, signature,
             cnt_alpha, cnt_beta, cnt_gamma
   );
endinterface

// File: rtl/mo_response_capture.sv
// rtl/mo_response_capture.sv - drives {A,B,C,D} through a vector sweep, counts ones per output
// and folds every response into a 16-bit MISR signature.
module mo_response_capture #(
   parameter int          NUM_VECTORS = 16,
   parameter int          CNT_W       = 5,
   parameter logic [15:0] SEED        = 16'hFFFF,
   parameter logic [15:0] POLY        = 16'h100B
) (
   input  logic                 clk,
   input  logic                 rst,
   mo_response_capture_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic             w_load;
   logic             w_sample;
   logic             w_last;

   logic [CNT_W-1:0] r_idx;
   logic [CNT_W-1:0] w_idx_next;
   logic [3:0]       r_vec;
   logic             r_valid;
   logic [15:0]      r_sig;
   logic [15:0]      w_sig_next;
   logic [CNT_W-1:0] r_cnt_a;
   logic [CNT_W-1:0] r_cnt_b;
   logic [CNT_W-1:0] r_cnt_g;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // abort wins over everything, including a start seen in IDLE
   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_sample     = 1'b0;
      w_last       = 1'b0;
      if (bus.abort) begin
         w_state_next = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  w_state_next = CAPTURE;
                  w_load       = 1'b1;
               end
            end
            CAPTURE: begin
               w_sample = 1'b1;
               if (r_idx == CNT_W'(NUM_VECTORS - 1)) begin
                  w_state_next = DONE;
                  w_last       = 1'b1;
               end
            end
            DONE: begin
               w_state_next = IDLE;
            end
            default: begin
               w_state_next = IDLE;
            end
         endcase
      end
   end

   assign w_idx_next = r_idx + CNT_W'(1);

   // Galois-style MISR: shift, fold in POLY on carry-out, then xor the three responses into the low bits
   assign w_sig_next = {r_sig[14:0], 1'b0}
                     ^ (r_sig[15] ? POLY : 16'h0000)
                     ^ {13'b0, bus.Falpha, bus.Fbeta, bus.Fgamma};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx   <= '0;
         r_vec   <= 4'd0;
         r_valid <= 1'b0;
         r_sig   <= 16'h0000;
         r_cnt_a <= '0;
         r_cnt_b <= '0;
         r_cnt_g <= '0;
      end else if (bus.abort) begin
         r_vec   <= 4'd0;
         r_valid <= 1'b0;
      end else if (w_load) begin
         r_idx   <= '0;
         r_vec   <= 4'd0;
         r_valid <= 1'b0;
         r_sig   <= SEED;
         r_cnt_a <= '0;
         r_cnt_b <= '0;
         r_cnt_g <= '0;
      end else if (w_sample) begin
         r_idx   <= w_idx_next;
         r_sig   <= w_sig_next;
         r_cnt_a <= r_cnt_a + CNT_W'(bus.Falpha);
         r_cnt_b <= r_cnt_b + CNT_W'(bus.Fbeta);
         r_cnt_g <= r_cnt_g + CNT_W'(bus.Fgamma);
         // vectors wrap modulo 16; the circuit is parked at 0 once the last sample is in
         r_vec   <= w_last ? 4'd0 : 4'(w_idx_next);
         if (w_last) begin
            r_valid <= 1'b1;
         end
      end
   end

   assign bus.vec_out      = r_vec;
   assign bus.busy         = (r_state == CAPTURE);
   assign bus.done         = (r_state == DONE);
   assign bus.result_valid = r_valid;
   assign bus.signature    = r_sig;
   assign bus.cnt_alpha    = r_cnt_a;
   assign bus.cnt_beta     = r_cnt_b;
   assign bus.cnt_gamma    = r_cnt_g;

endmodule

// File: tb/tb_mo_response_capture.sv
// tb/tb_mo_response_capture.sv - scoreboard bench for mo_response_capture.
module tb_mo_response_capture;
   localparam int CNT_W = 5;

   typedef struct {
      logic [15:0] sig;
      int          ca;
      int          cb;
      int          cg;
   } exp_t;

   logic clk;
   logic rst;
   int   mode;
   int   tests;
   int   fails;
   int   bcnt;
   int   d0_dones;
   exp_t sb[$];

   mo_response_capture_if #(.CNT_W(CNT_W)) bus ();
   mo_response_capture_if #(.CNT_W(CNT_W)) bus0 ();

   mo_response_capture #(
      .NUM_VECTORS(16), .CNT_W(CNT_W), .SEED(16'hFFFF), .POLY(16'h100B)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus.slave)
   );

   mo_response_capture #(
      .NUM_VECTORS(16), .CNT_W(CNT_W), .SEED(16'h0000), .POLY(16'h100B)
   ) dut0 (
      .clk(clk), .rst(rst), .bus(bus0.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0] resp(input int m, input logic [3:0] v);
      logic a, b, c, d;
      {a, b, c, d} = v;
      case (m)
         0:       return 3'b100;
         1:       return {1'b0, a & ~b, d};
         3:       return {(a & b) | c, b ^ d, ~a & ~d};
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [15:0] misr_model(input logic [15:0] seed, input int m);
      logic [15:0] s;
      logic        fb;
      s = seed;
      for (int v = 0; v < 16; v++) begin
         fb = s[15];
         s  = s << 1;
         if (fb) s = s ^ 16'h100B;
         s = s ^ {13'b0, resp(m, 4'(v))};
      end
      return s;
   endfunction

   assign {bus.Falpha, bus.Fbeta, bus.Fgamma} = resp(mode, bus.vec_out);
   assign bus0.start  = bus.start;
   assign bus0.abort  = 1'b0;
   assign bus0.Falpha = 1'b0;
   assign bus0.Fbeta  = 1'b0;
   assign bus0.Fgamma = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic start_run(input int m, input bit expect_done, input int ca, input int cb, input int cg);
      exp_t e;
      @(negedge clk);
      mode = m;
      if (expect_done) begin
         e.sig = misr_model(16'hFFFF, m);
         e.ca  = ca;
         e.cb  = cb;
         e.cg  = cg;
         sb.push_back(e);
      end
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (bus.done) seen = 1'b1;
      end
      if (!seen) chk("done_timeout", 32'd0, 32'd1);
   endtask

   // scoreboard monitor: steps vec_out during CAPTURE and pops one expectation per done pulse
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         bcnt = 0;
      end else if (bus.busy) begin
         chk("vec_step", 32'(bus.vec_out), 32'(bcnt % 16));
         bcnt++;
      end else if (bus.done) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL done_unexpected: got done=1 expected no pulse");
         end else begin
            e = sb.pop_front();
            chk("signature", 32'(bus.signature), 32'(e.sig));
            chk("cnt_alpha", 32'(bus.cnt_alpha), 32'(e.ca));
            chk("cnt_beta", 32'(bus.cnt_beta), 32'(e.cb));
            chk("cnt_gamma", 32'(bus.cnt_gamma), 32'(e.cg));
            chk("valid_at_done", 32'(bus.result_valid), 32'd1);
            chk("busy_cycles", 32'(bcnt), 32'd16);
            chk("vec_parked", 32'(bus.vec_out), 32'd0);
         end
         bcnt = 0;
      end else begin
         bcnt = 0;
      end
   end

   always @(negedge clk) begin
      if (!rst && bus0.done) begin
         chk("seed0_signature", 32'(bus0.signature), 32'd0);
         chk("seed0_counts", 32'({bus0.cnt_alpha, bus0.cnt_beta, bus0.cnt_gamma}), 32'd0);
         d0_dones++;
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_vec"}, 32'(bus.vec_out), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_done"}, 32'(bus.done), 32'd0);
      chk({tag, "_valid"}, 32'(bus.result_valid), 32'd0);
      chk({tag, "_sig"}, 32'(bus.signature), 32'd0);
      chk({tag, "_cnts"}, 32'({bus.cnt_alpha, bus.cnt_beta, bus.cnt_gamma}), 32'd0);
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      bcnt      = 0;
      d0_dones  = 0;
      mode      = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;

      start_run(0, 1'b1, 16, 0, 0);
      wait_done();
      repeat (2) @(negedge clk);
      chk("valid_hold", 32'(bus.result_valid), 32'd1);
      chk("idle_busy", 32'(bus.busy), 32'd0);

      start_run(1, 1'b1, 0, 4, 8);
      wait_done();
      start_run(2, 1'b1, 0, 0, 0);
      wait_done();
      start_run(3, 1'b1, 10, 8, 4);
      wait_done();
      start_run(3, 1'b1, 10, 8, 4);
      wait_done();

      // abort sampled on the edge ending the 5th capture cycle: four samples already taken
      start_run(0, 1'b0, 0, 0, 0);
      repeat (4) @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_valid", 32'(bus.result_valid), 32'd0);
      chk("abort_vec", 32'(bus.vec_out), 32'd0);
      chk("abort_cnt_alpha", 32'(bus.cnt_alpha), 32'd4);
      start_run(0, 1'b1, 16, 0, 0);
      wait_done();

      start_run(3, 1'b0, 0, 0, 0);
      repeat (6) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk_all_zero("async_rst");
      @(negedge clk);
      rst = 1'b0;

      start_run(3, 1'b1, 10, 8, 4);
      repeat (5) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done();
      repeat (3) @(negedge clk);
      chk("no_restart_busy", 32'(bus.busy), 32'd0);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      chk("seed0_runs_seen", 32'(d0_dones > 0), 32'd1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
